// File: rtl/seven_seg_pkg.sv
// Shared codes, widths and the nibble sanitiser for the seven-segment scan controller.
// The downstream decoder only understands codes 0-9, 10 ('-'), 11 ('r') and 14 ('E').
package seven_seg_pkg;

    localparam logic [3:0] CODE_DASH  = 4'd10;
    localparam logic [3:0] CODE_R     = 4'd11;
    localparam logic [3:0] CODE_E     = 4'd14;
    localparam int         SEL_W      = 2;
    localparam int         NUM_DIGITS = 4;

    // Codes the decoder leaves undefined are shown as a dash rather than garbage.
    function automatic logic [3:0] sanitise_code(input logic [3:0] nibble);
        case (nibble)
            4'd12, 4'd13, 4'd15: return CODE_DASH;
            default:             return nibble;
        endcase
    endfunction

endpackage

// File: rtl/seven_seg_prescaler.sv
// Divides clk into digit slots; tick is high for the last cycle of every slot.
// tick is registered, so it is set on the edge where the counter reaches its last value.
module seven_seg_prescaler #(
    parameter  int REFRESH_DIV = 100000,
    localparam int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(REFRESH_DIV - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
            tick <= (cnt == CNT_PRE_LAST);
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit scan controller: walks sel across the digits and presents the matching code.
// New words are double-buffered and only become visible at a frame boundary.
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [15:0]      value,
    input  logic             err,
    output logic [SEL_W-1:0] sel,
    output logic [3:0]       digit,
    output logic             tick,
    output logic             load_ack
);

    logic [15:0] active_word;
    logic [15:0] pending_word;
    logic        pending;
    logic        err_active;
    logic [15:0] clean_value;
    logic        boundary;

    seven_seg_prescaler #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        clean_value = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            clean_value[4*d +: 4] = sanitise_code(value[4*d +: 4]);
        end
    end

    assign boundary = tick && (sel == SEL_W'(NUM_DIGITS - 1));

    // Handshake: load is a fire-and-forget strobe with no back-pressure; the pending word
    // can be overwritten any time, and load_ack pulses once when the latest one is committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel          <= '0;
            active_word  <= '0;
            pending_word <= '0;
            pending      <= 1'b0;
            err_active   <= 1'b0;
            load_ack     <= 1'b0;
        end else begin
            load_ack <= 1'b0;
            if (tick) begin
                sel <= sel + SEL_W'(1);
            end
            if (boundary) begin
                err_active <= err;
                if (pending) begin
                    active_word <= pending_word;
                    pending     <= 1'b0;
                    load_ack    <= 1'b1;
                end
            end
            // A load on the boundary edge wins over the clear so the new word waits a frame.
            if (load) begin
                pending_word <= clean_value;
                pending      <= 1'b1;
            end
        end
    end

    always_comb begin
        digit = active_word[15:12];
        if (err_active) begin
            case (sel)
                2'd0:    digit = CODE_DASH;
                2'd1:    digit = CODE_E;
                default: digit = CODE_R;
            endcase
        end else begin
            case (sel)
                2'd0:    digit = active_word[15:12];
                2'd1:    digit = active_word[11:8];
                2'd2:    digit = active_word[7:4];
                default: digit = active_word[3:0];
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl with a 4-cycle digit slot (16-cycle frame).
// Each frame is checked cycle by cycle against the word expected to be on display.
module tb_seven_seg_scan_ctrl;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic        err;
    logic [1:0]  sel;
    logic [3:0]  digit;
    logic        tick;
    logic        load_ack;

    seven_seg_scan_ctrl #(
        .REFRESH_DIV (DIV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .value    (value),
        .err      (err),
        .sel      (sel),
        .digit    (digit),
        .tick     (tick),
        .load_ack (load_ack)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;

    // scoreboard: words loaded but not yet expected on the display
    logic [15:0] exp_q[$];
    logic [15:0] cur_word;
    logic        cur_err;
    logic        commit_next;

    typedef struct {
        int          ld_at;
        logic [15:0] ld_val;
        logic [15:0] ld_exp;
        int          ld2_at;
        logic [15:0] ld2_val;
        logic [15:0] ld2_exp;
        int          err_at;
        logic        err_val;
    } vec_t;

    vec_t vecs[12];
    vec_t quiet;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // driver: a load at the boundary slot always queues behind the word committing on that edge
    task automatic drive_load(input logic [15:0] v, input logic [15:0] e, input logic on_boundary);
        load  = 1'b1;
        value = v;
        if (on_boundary || exp_q.size() == 0) exp_q.push_back(e);
        else exp_q[exp_q.size()-1] = e;
    endtask

    task automatic run_frame(input vec_t v);
        logic [15:0] shown;
        logic        exp_ack;
        exp_ack = 1'b0;
        if (commit_next && exp_q.size() != 0) begin
            cur_word = exp_q.pop_front();
            exp_ack  = 1'b1;
        end
        shown = cur_err ? 16'hAEBB : cur_word;
        for (int i = 0; i < 4 * DIV; i++) begin
            int s;
            s = i / DIV;
            chk("sel", {14'd0, sel}, 16'(s));
            chk("digit", {12'd0, digit}, {12'd0, shown[4*(3-s) +: 4]});
            chk("tick", {15'd0, tick}, (i % DIV == DIV - 1) ? 16'd1 : 16'd0);
            chk("load_ack", {15'd0, load_ack}, (i == 0 && exp_ack) ? 16'd1 : 16'd0);
            if (i == 4 * DIV - 1) commit_next = (exp_q.size() != 0);
            load = 1'b0;
            if (i == v.ld_at)  drive_load(v.ld_val, v.ld_exp, i == 4 * DIV - 1);
            if (i == v.ld2_at) drive_load(v.ld2_val, v.ld2_exp, i == 4 * DIV - 1);
            if (i == v.err_at) err = v.err_val;
            step();
        end
        cur_err = err;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_sel", {14'd0, sel}, 16'd0);
        chk("rst_digit", {12'd0, digit}, 16'd0);
        chk("rst_tick", {15'd0, tick}, 16'd0);
        chk("rst_load_ack", {15'd0, load_ack}, 16'd0);
    endtask

    task automatic clear_model();
        exp_q.delete();
        cur_word    = 16'h0000;
        cur_err     = 1'b0;
        commit_next = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        load     = 1'b0;
        value    = 16'h0000;
        err      = 1'b0;
        clear_model();

        quiet = '{-1, 16'h0, 16'h0, -1, 16'h0, 16'h0, -1, 1'b0};
        //            ld_at ld_val    ld_exp    ld2  ld2_val   ld2_exp   err_at err_val
        vecs[0]  = '{ 2,   16'h1111, 16'h1111, 10, 16'h2222, 16'h2222, -1, 1'b0};
        vecs[1]  = '{ 7,   16'hCDF9, 16'hAAA9, -1, 16'h0,    16'h0,    -1, 1'b0};
        vecs[2]  = '{ 4,   16'hABE0, 16'hABE0, -1, 16'h0,    16'h0,    -1, 1'b0};
        vecs[3]  = '{-1,   16'h0,    16'h0,    -1, 16'h0,    16'h0,     6, 1'b1};
        vecs[4]  = '{ 3,   16'h9876, 16'h9876, -1, 16'h0,    16'h0,    -1, 1'b0};
        vecs[5]  = '{-1,   16'h0,    16'h0,    -1, 16'h0,    16'h0,     9, 1'b0};
        vecs[6]  = '{15,   16'h4321, 16'h4321, -1, 16'h0,    16'h0,    -1, 1'b0};
        vecs[7]  = '{ 2,   16'h1357, 16'h1357, 15, 16'h2468, 16'h2468, -1, 1'b0};
        vecs[8]  = quiet;
        vecs[9]  = '{ 0,   16'hFEDC, 16'hAEAA, -1, 16'h0,    16'h0,    -1, 1'b0};
        vecs[10] = quiet;
        vecs[11] = quiet;

        // reset held through a clock edge
        @(posedge clk);
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // load before the first boundary, then a deferred load at sel=1
        begin
            vec_t v;
            v = quiet; v.ld_at = 5; v.ld_val = 16'h1234; v.ld_exp = 16'h1234;
            run_frame(v);
            v = quiet; v.ld_at = 6; v.ld_val = 16'h5678; v.ld_exp = 16'h5678;
            run_frame(v);
        end
        run_frame(quiet);
        run_frame(quiet);

        for (int k = 0; k < 12; k++) begin
            run_frame(vecs[k]);
        end

        // reset mid-frame with a word pending: it must be discarded without an ack
        load  = 1'b1;
        value = 16'h7777;
        step();
        load = 1'b0;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        clear_model();
        err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_frame(quiet);
        run_frame(quiet);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
